pipemem_access: RTL and testbench
=================================

Name: pipemem_access

Overview:
MEM-stage memory-access controller, directly downstream of the EXE/MEM pipeline register.
- Consumes the MEM-stage control and data (mwreg, mm2reg, mwmem, malu, mb, mrn).
- Runs loads and stores against a variable-latency data bus using a req/ack handshake.
- Stalls the pipeline while an access is outstanding.
- Contains the MEM/WB pipeline register that feeds writeback.

Parameters:
TIMEOUT, 15, max WAIT cycles without bus_ack before the access is aborted (must be >=1)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
mwreg  in  1  MEM-stage register-write enable
mm2reg  in  1  MEM-stage load (result comes from memory)
mwmem  in  1  MEM-stage store
malu  in  32  ALU result; byte address for loads/stores
mb  in  32  store data
mrn  in  5  destination register number
bus_ack  in  1  memory completes the current request this cycle
bus_rdata  in  32  load data, valid when bus_ack=1
bus_req  out  1  access request
bus_we  out  1  1=write, 0=read
bus_addr  out  32  word-aligned address
bus_wdata  out  32  write data
mstall  out  1  freeze PC, IF/ID, ID/EXE and EXE/MEM this cycle
merr  out  1  one-cycle pulse on misaligned access or timeout
wwreg  out  1  WB register-write enable
wm2reg  out  1  WB select-memory
wmo  out  32  WB memory data
walu  out  32  WB ALU result
wrn  out  5  WB destination register

Behaviour:
Reset:
- state=IDLE, wait counter=0.
- All registered outputs are 0: wwreg, wm2reg, wmo, walu, wrn, merr.
- bus_req=0 and mstall=0 in the cycle after the reset edge.

Definitions:
- memop = mwmem | mm2reg.
- If mwmem=mm2reg=1, the access is a store (mm2reg is ignored for the bus), but WB still sees mm2reg.

IDLE state:
- memop=0: no bus activity, mstall=0. The MEM/WB register captures the inputs at the edge; wmo captures 0.
- memop=1 and malu[1:0]!=0 (misaligned):
  - No bus_req, mstall=0.
  - At the edge: merr=1, wwreg=0, wm2reg=0, walu/wrn captured normally.
- memop=1 and aligned:
  - Combinational outputs: bus_req=1, bus_we=mwmem, bus_addr=malu, bus_wdata=mb.
  - bus_ack=1 in the same cycle: zero-wait completion; mstall=0; the WB register captures bus_rdata into wmo.
  - bus_ack=0: mstall=1; at the edge, go to WAIT, latch addr/we/wdata, counter=1, and write a bubble into WB.

WAIT state:
- bus_req=1, driven from the latched values so they are stable while req is high.
- mstall=1 in every cycle except the completion cycle.
- bus_ack=1: mstall=0; the WB register captures mwreg, mm2reg, bus_rdata (or 0 for stores), malu, mrn; next state IDLE.
- No ack and counter==TIMEOUT (abort):
  - mstall=0; next state IDLE.
  - At the edge: merr=1, wwreg=0, wm2reg=0, wmo=0.
- Otherwise the counter increments.

Bubble (any cycle with mstall=1): at the edge, wwreg=0 and wm2reg=0; walu, wmo and wrn hold.

Boundaries and ordering:
- Latency: 1 cycle to WB with zero-wait memory; N+1 cycles with N wait cycles.
- The upstream EXE/MEM register holds its outputs while mstall=1; the block does not rely on this, since it uses its latched bus copy.
- bus_ack while bus_req=0 is ignored.
- Reset in WAIT: drop to IDLE; the request is abandoned and WB is not written.
- merr is never asserted in two consecutive cycles due to the same instruction.

Decomposition:
Shared package pipe_pkg holds:
- State encoding IDLE=1'b0, WAIT=1'b1.
- Default TIMEOUT.
- Bubble value and the abort data value (32'h0).

The counter width is derived from TIMEOUT.

One sub-module, pipemwreg: the MEM/WB register, with inputs bubble and wwreg/wm2reg/wmo/walu/wrn and synchronous active-high reset. The FSM, counter and bus muxing stay in pipemem_access.

Test Plan:
1. Reset held 2 cycles mid-WAIT (addr 0x100) -> bus_req=0 and all W outputs 0 the cycle after; a later bus_ack is ignored.
2. ALU op mwreg=1, malu=0x1234, mrn=5 -> next cycle wwreg=1, walu=0x1234, wrn=5, wmo=0, mstall never 1.
3. Load malu=0x40, ack same cycle, bus_rdata=0xCAFEF00D -> no stall, next cycle wm2reg=1, wmo=0xCAFEF00D.
4. Store malu=0x80, mb=0x55AA, ack after 3 WAIT cycles -> bus_we=1, bus_addr=0x80, bus_wdata=0x55AA stable 4 cycles; mstall=1 for 3 cycles; 3 bubbles (wwreg=0) then completion.
5. Load with ack never asserted, TIMEOUT=15 -> mstall high 15 cycles, then merr pulse 1 cycle, wwreg=0, wmo=0, state returns to IDLE.
6. Load malu=0x42 (misaligned) -> no bus_req, mstall=0, merr=1 for one cycle, wwreg=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the MEM-stage access controller and its MEM/WB register.
// Holds the FSM encoding, the default timeout, and the fixed data values for bubbles and aborts.
package pipe_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int          TIMEOUT_DEF = 15;
  localparam logic [31:0] BUBBLE_VAL  = 32'h0;
  localparam logic [31:0] ABORT_DATA  = 32'h0;

  // Wide enough to hold the value TIMEOUT itself.
  function automatic int cnt_width(input int t);
    return (t < 2) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/pipemem_access_pipemwreg.sv
// MEM/WB pipeline register: 1-cycle capture; on bubble it clears the write enables and holds the data.
// Synchronous active-high reset clears every field.
module pipemwreg (
  input  logic        clock,
  input  logic        reset,
  input  logic        bubble,
  input  logic        d_wwreg,
  input  logic        d_wm2reg,
  input  logic [31:0] d_wmo,
  input  logic [31:0] d_walu,
  input  logic [4:0]  d_wrn,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [4:0]  wrn
);

  always_ff @(posedge clock) begin
    if (reset) begin
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
      wmo    <= 32'h0;
      walu   <= 32'h0;
      wrn    <= 5'd0;
    end else if (bubble) begin
      wwreg  <= 1'b0;
      wm2reg <= 1'b0;
    end else begin
      wwreg  <= d_wwreg;
      wm2reg <= d_wm2reg;
      wmo    <= d_wmo;
      walu   <= d_walu;
      wrn    <= d_wrn;
    end
  end

endmodule

// File: rtl/pipemem_access.sv
// MEM-stage load/store controller: 1 cycle to WB with zero-wait memory, N+1 with N wait cycles.
// Holds mstall high while a bus access is outstanding; aborts with merr after TIMEOUT wait cycles.
module pipemem_access
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  input  logic [4:0]  mrn,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        mstall,
  output logic        merr,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [4:0]  wrn
);

  localparam int          CW   = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] C_TO = CW'(TIMEOUT);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic            r_we;
  logic            r_merr;

  logic            w_memop;
  logic            w_misalign;
  logic            w_access;
  logic            w_timeout;
  logic            w_err;
  logic            w_load;
  logic [31:0]     w_wmo;

  assign w_memop    = mwmem | mm2reg;
  assign w_misalign = w_memop & (malu[1:0] != 2'b00);
  assign w_access   = w_memop & ~w_misalign;
  // Ack on the last allowed wait cycle still counts as a completion.
  assign w_timeout  = (r_state == WAIT) & ~bus_ack & (r_cnt == C_TO);
  assign w_err      = (r_state == IDLE) ? w_misalign : w_timeout;
  assign w_load     = (r_state == WAIT) ? ~r_we : (w_access & ~mwmem);
  assign w_wmo      = (w_load & ~w_err) ? bus_rdata :
                      (w_memop ? ABORT_DATA : BUBBLE_VAL);
  assign merr       = r_merr;

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_access & ~bus_ack) w_next = WAIT;
      WAIT:    if (bus_ack | w_timeout) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus_req   = 1'b0;
    bus_we    = mwmem;
    bus_addr  = {malu[31:2], 2'b00};
    bus_wdata = mb;
    mstall    = 1'b0;
    case (r_state)
      IDLE: begin
        bus_req = w_access;
        mstall  = w_access & ~bus_ack;
      end
      WAIT: begin
        bus_req   = 1'b1;
        bus_we    = r_we;
        bus_addr  = r_addr;
        bus_wdata = r_wdata;
        mstall    = ~bus_ack & ~w_timeout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt   <= '0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_we    <= 1'b0;
      r_merr  <= 1'b0;
    end else begin
      r_merr <= w_err;
      if (r_state == IDLE) begin
        if (w_access & ~bus_ack) begin
          r_cnt   <= CW'(1);
          r_addr  <= {malu[31:2], 2'b00};
          r_we    <= mwmem;
          r_wdata <= mb;
        end
      end else if (bus_ack | w_timeout) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  pipemwreg u_mwreg (
    .clock    (clock),
    .reset    (reset),
    .bubble   (mstall),
    .d_wwreg  (mwreg & ~w_err),
    .d_wm2reg (mm2reg & ~w_err),
    .d_wmo    (w_wmo),
    .d_walu   (malu),
    .d_wrn    (mrn),
    .wwreg    (wwreg),
    .wm2reg   (wm2reg),
    .wmo      (wmo),
    .walu     (walu),
    .wrn      (wrn)
  );

endmodule

// File: tb/tb_pipemem_access.sv
// Bench for pipemem_access: directed scenarios then random instructions against a per-instruction model
// that predicts stall length, bus contents and the MEM/WB result from the ack delay.
module tb_pipemem_access;

  localparam int TO = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic        mwreg, mm2reg, mwmem;
  logic [31:0] malu, mb;
  logic [4:0]  mrn;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_req, bus_we, mstall, merr, wwreg, wm2reg;
  logic [31:0] bus_addr, bus_wdata, wmo, walu;
  logic [4:0]  wrn;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_walu, m_wmo;
  logic [4:0]  m_wrn;

  pipemem_access #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .malu(malu), .mb(mb), .mrn(mrn), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .mstall(mstall), .merr(merr), .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo),
    .walu(walu), .wrn(wrn)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic m2, input logic wm,
                       input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn);
    mwreg = wr; mm2reg = m2; mwmem = wm; malu = alu; mb = b; mrn = rn;
  endtask

  task automatic chk_wb(input string tag, input logic e_wwreg, input logic e_wm2reg,
                        input logic [31:0] e_wmo, input logic [31:0] e_walu,
                        input logic [4:0] e_wrn, input logic e_merr);
    chk({tag, ".wwreg"}, wwreg, e_wwreg);
    chk({tag, ".wm2reg"}, wm2reg, e_wm2reg);
    chk({tag, ".wmo"}, wmo, e_wmo);
    chk({tag, ".walu"}, walu, e_walu);
    chk({tag, ".wrn"}, wrn, e_wrn);
    chk({tag, ".merr"}, merr, e_merr);
  endtask

  // Caller is at a negedge. delay = cycle index (from the first request cycle) on which ack is raised;
  // anything beyond TO means the memory never answers.
  task automatic run_instr(input logic wr, input logic m2, input logic wm,
                           input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn,
                           input int delay, input logic [31:0] rdata);
    logic acc, mis, err;
    int   s;
    logic [31:0] e_wmo;
    mis = (wm | m2) && (alu[1:0] != 2'b00);
    acc = (wm | m2) && !mis;
    s   = acc ? ((delay < TO) ? delay : TO) : 0;
    err = mis || (acc && delay > TO);
    for (int cyc = 0; cyc <= s; cyc++) begin
      drive(wr, m2, wm, alu, b, rn);
      bus_ack   = (cyc == delay);
      bus_rdata = acc ? (wm ? 32'h0 : rdata) : $urandom;
      #1;
      chk("bus_req", bus_req, acc);
      chk("mstall", mstall, cyc < s);
      if (acc) begin
        chk("bus_we", bus_we, wm);
        chk("bus_addr", bus_addr, alu);
        chk("bus_wdata", bus_wdata, b);
      end
      @(negedge clock);
      if (cyc < s) chk_wb("bubble", 1'b0, 1'b0, m_wmo, m_walu, m_wrn, 1'b0);
    end
    e_wmo = (acc && !wm && !err) ? rdata : 32'h0;
    chk_wb("wb", err ? 1'b0 : wr, err ? 1'b0 : m2, e_wmo, alu, rn, err);
    m_wmo = e_wmo; m_walu = alu; m_wrn = rn;
    bus_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] alu;
    int          kind, r, dly;

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(negedge clock);
    chk("rst.bus_req", bus_req, 1'b0);
    chk("rst.mstall", mstall, 1'b0);
    chk_wb("rst", 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    reset = 1'b0;
    m_walu = 32'h0; m_wmo = 32'h0; m_wrn = 5'd0;

    // Reset taken while a load at 0x100 is waiting on the bus.
    drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd7);
    #1;
    chk("rw.bus_req", bus_req, 1'b1);
    chk("rw.mstall", mstall, 1'b1);
    repeat (2) @(negedge clock);
    chk("rw.wait_req", bus_req, 1'b1);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    @(negedge clock);
    chk("rw.rst_req", bus_req, 1'b0);
    chk("rw.rst_stall", mstall, 1'b0);
    chk_wb("rw.rst", 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    #1;
    chk("rw.stray_req", bus_req, 1'b0);
    chk("rw.stray_stall", mstall, 1'b0);
    @(negedge clock);
    chk_wb("rw.stray", 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    bus_ack = 1'b0;

    run_instr(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 1, 32'h0);
    run_instr(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd3, 0, 32'hCAFEF00D);
    run_instr(1'b0, 1'b0, 1'b1, 32'h80, 32'h55AA, 5'd0, 3, 32'h0);
    run_instr(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 5'd9, TO + 3, 32'h12345678);
    run_instr(1'b1, 1'b1, 1'b0, 32'h42, 32'h0, 5'd4, 1, 32'h0);
    run_instr(1'b1, 1'b1, 1'b0, 32'h48, 32'h0, 5'd6, TO, 32'hA5A5A5A5);
    run_instr(1'b1, 1'b1, 1'b1, 32'h4C, 32'h77, 5'd2, 2, 32'h0);

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 3);
      alu  = $urandom;
      if ($urandom_range(0, 7) != 0) alu[1:0] = 2'b00;
      r = $urandom_range(0, 9);
      if (r < 4)       dly = 0;
      else if (r < 8)  dly = $urandom_range(1, 4);
      else if (r < 9)  dly = TO;
      else             dly = TO + 1 + $urandom_range(0, 3);
      run_instr($urandom_range(0, 1) == 1, kind == 1 || kind == 3, kind >= 2,
                alu, $urandom, 5'($urandom), dly, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
